// File: rtl/seg7_pkg.sv
// Shared constants, glyph table and scan state type for the 7-segment scan path.
// Segment order is {g,f,e,d,c,b,a}, active-low throughout.
package seg7_pkg;

   localparam logic [6:0] SEG_OFF    = 7'h7F;
   localparam logic [3:0] CODE_BLANK = 4'hF;
   localparam logic [3:0] CODE_DASH  = 4'hA;

   localparam logic [6:0] GLYPH_0    = 7'h40;
   localparam logic [6:0] GLYPH_1    = 7'h79;
   localparam logic [6:0] GLYPH_2    = 7'h24;
   localparam logic [6:0] GLYPH_3    = 7'h30;
   localparam logic [6:0] GLYPH_4    = 7'h19;
   localparam logic [6:0] GLYPH_5    = 7'h12;
   localparam logic [6:0] GLYPH_6    = 7'h02;
   localparam logic [6:0] GLYPH_7    = 7'h78;
   localparam logic [6:0] GLYPH_8    = 7'h00;
   localparam logic [6:0] GLYPH_9    = 7'h10;
   localparam logic [6:0] GLYPH_DASH = 7'h3F;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_e;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit code to active-low segment decoder; 0-9 digits, A dash, B-F blank.
// Latency: zero cycles; backpressure: none.
module seg7_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      case (code)
         4'h0:      seg = GLYPH_0;
         4'h1:      seg = GLYPH_1;
         4'h2:      seg = GLYPH_2;
         4'h3:      seg = GLYPH_3;
         4'h4:      seg = GLYPH_4;
         4'h5:      seg = GLYPH_5;
         4'h6:      seg = GLYPH_6;
         4'h7:      seg = GLYPH_7;
         4'h8:      seg = GLYPH_8;
         4'h9:      seg = GLYPH_9;
         CODE_DASH: seg = GLYPH_DASH;
         default:   seg = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg7_scan_scheduler.sv
// Round-robin digit scanner with per-slot blanking and frame-atomic double-buffered data.
// Latency: outputs registered, new data visible at next frame; no backpressure; blink built only with SEG7_BLINK_EN.
module seg7_scan_scheduler
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 7,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int BLINK_DIV    = 12500000
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [4*NUM_DIGITS-1:0]       digit_data,
   input  logic                          data_valid,
   input  logic [NUM_DIGITS-1:0]         digit_en,
   input  logic [NUM_DIGITS-1:0]         blink_mask,
   output logic [NUM_DIGITS-1:0]         trans,
   output logic [6:0]                    led7seg,
   output logic                          commit,
   output logic [$clog2(NUM_DIGITS)-1:0] cur_digit
);

   localparam int DW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   scan_state_e                  state_q, state_n;
   logic [CW-1:0]                cnt_q, cnt_n;
   logic [DW-1:0]                dig_n;
   logic [NUM_DIGITS-1:0][3:0]   pend_q, shadow_q;
   logic                         pend_flag_q;
   logic                         boundary, commit_n;

   logic [DW-1:0]                next_idx, hi_idx, lo_idx;
   logic                         hi_vld, lo_vld, next_wrap;

   logic [3:0]                   cur_code;
   logic [6:0]                   cur_glyph;
   logic                         mask_cur;
   logic [NUM_DIGITS-1:0]        trans_n;
   logic [6:0]                   led_n;

   // Lowest enabled index above cur_digit, else lowest enabled overall (a wrap).
   always_comb begin
      hi_vld = 1'b0;
      hi_idx = '0;
      lo_vld = 1'b0;
      lo_idx = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (digit_en[i]) begin
            lo_vld = 1'b1;
            lo_idx = DW'(i);
            if (i > int'(cur_digit)) begin
               hi_vld = 1'b1;
               hi_idx = DW'(i);
            end
         end
      end
      next_wrap = ~hi_vld;
      next_idx  = hi_vld ? hi_idx : (lo_vld ? lo_idx : cur_digit);
   end

   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      dig_n    = cur_digit;
      boundary = 1'b0;
      case (state_q)
         BLANK: begin
            if (digit_en == '0) begin
               cnt_n    = '0;
               boundary = 1'b1;
            end else if (cnt_q == BLANK_LAST) begin
               if (digit_en[cur_digit]) begin
                  state_n = DRIVE;
                  cnt_n   = cnt_q + 1'b1;
               end else begin
                  // Slot landed on a digit that is now disabled: skip it without lighting it.
                  cnt_n    = '0;
                  dig_n    = next_idx;
                  boundary = next_wrap;
               end
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         DRIVE: begin
            if (!digit_en[cur_digit] || cnt_q == SLOT_LAST) begin
               state_n  = BLANK;
               cnt_n    = '0;
               dig_n    = next_idx;
               boundary = next_wrap;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         default: begin
            state_n = BLANK;
            cnt_n   = '0;
         end
      endcase
   end

   assign commit_n = boundary & (pend_flag_q | data_valid);

   assign cur_code = shadow_q[cur_digit];

   seg7_decoder u_decoder (
      .code (cur_code),
      .seg  (cur_glyph)
   );

`ifdef SEG7_BLINK_EN
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [BW-1:0] blink_cnt_q;
   logic          blink_phase_q, blink_phase_n;

   assign blink_phase_n = (blink_cnt_q == BLINK_LAST) ? ~blink_phase_q : blink_phase_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         blink_cnt_q   <= (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
         blink_phase_q <= blink_phase_n;
      end
   end

   // Uses the upcoming phase so the masked output lines up with the phase register.
   assign mask_cur = blink_phase_n & blink_mask[cur_digit];
`else
   logic unused_blink_mask;
   assign unused_blink_mask = ^blink_mask;
   assign mask_cur          = 1'b0;
`endif

   // DRIVE never changes digit or shadow on its entry edge, so current values are safe here.
   always_comb begin
      trans_n = '1;
      led_n   = SEG_OFF;
      if (state_n == DRIVE) begin
         trans_n[cur_digit] = 1'b0;
         led_n              = mask_cur ? SEG_OFF : cur_glyph;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= BLANK;
         cnt_q     <= '0;
         cur_digit <= '0;
         trans     <= '1;
         led7seg   <= SEG_OFF;
         commit    <= 1'b0;
      end else begin
         state_q   <= state_n;
         cnt_q     <= cnt_n;
         cur_digit <= dig_n;
         trans     <= trans_n;
         led7seg   <= led_n;
         commit    <= commit_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q      <= {NUM_DIGITS{CODE_BLANK}};
         shadow_q    <= {NUM_DIGITS{CODE_BLANK}};
         pend_flag_q <= 1'b0;
      end else begin
         if (data_valid) begin
            pend_q <= digit_data;
         end
         if (commit_n) begin
            shadow_q    <= data_valid ? digit_data : pend_q;
            pend_flag_q <= 1'b0;
         end else if (data_valid) begin
            pend_flag_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Directed bench for seg7_scan_scheduler with a cycle-level behavioural model and literal spot checks.
module tb_seg7_scan_scheduler;

   localparam int ND = 7;
   localparam int SD = 10;
   localparam int BC = 2;
   localparam int BD = 40;
`ifdef SEG7_BLINK_EN
   localparam bit BLINK_ON = 1'b1;
`else
   localparam bit BLINK_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4*ND-1:0] digit_data = '0;
   logic          data_valid = 1'b0;
   logic [ND-1:0] digit_en = 7'h7F;
   logic [ND-1:0] blink_mask = '0;
   logic [ND-1:0] trans;
   logic [6:0]    led7seg;
   logic          commit;
   logic [2:0]    cur_digit;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seg7_scan_scheduler #(
      .NUM_DIGITS   (ND),
      .SCAN_DIV     (SD),
      .BLANK_CYCLES (BC),
      .BLINK_DIV    (BD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .digit_data (digit_data),
      .data_valid (data_valid),
      .digit_en   (digit_en),
      .blink_mask (blink_mask),
      .trans      (trans),
      .led7seg    (led7seg),
      .commit     (commit),
      .cur_digit  (cur_digit)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] c);
      case (c)
         4'h0: return 7'h40;
         4'h1: return 7'h79;
         4'h2: return 7'h24;
         4'h3: return 7'h30;
         4'h4: return 7'h19;
         4'h5: return 7'h12;
         4'h6: return 7'h02;
         4'h7: return 7'h78;
         4'h8: return 7'h00;
         4'h9: return 7'h10;
         4'hA: return 7'h3F;
         default: return 7'h7F;
      endcase
   endfunction

   // Model: position within the slot, current digit, cycle count since reset, and both buffers.
   bit         m_live = 1'b0;
   int         m_pos, m_dig, m_n;
   logic [3:0] m_pend [ND];
   logic [3:0] m_shad [ND];
   bit         m_flag, m_commit;
   logic [ND-1:0] m_bm;

   always @(posedge clk) begin : model
      bit adv, bnd, cm;
      int nd;
      logic [ND-1:0] en;
      en = digit_en;
      if (rst) begin
         m_live = 1'b1;
         m_pos = 0; m_dig = 0; m_n = 0;
         m_flag = 1'b0; m_commit = 1'b0; m_bm = '0;
         for (int i = 0; i < ND; i++) begin
            m_pend[i] = 4'hF;
            m_shad[i] = 4'hF;
         end
      end else if (m_live) begin
         adv = 1'b0;
         bnd = 1'b0;
         m_n++;
         if (m_pos < BC) begin
            if (en == '0) begin
               m_pos = 0;
               bnd = 1'b1;
            end else if (m_pos == BC - 1 && !en[m_dig]) adv = 1'b1;
            else m_pos++;
         end else begin
            if (!en[m_dig] || m_pos == SD - 1) adv = 1'b1;
            else m_pos++;
         end
         if (adv) begin
            m_pos = 0;
            nd = -1;
            for (int j = m_dig + 1; j < ND; j++) if (en[j] && nd < 0) nd = j;
            if (nd < 0) begin
               bnd = 1'b1;
               for (int j = 0; j < ND; j++) if (en[j] && nd < 0) nd = j;
            end
            if (nd >= 0) m_dig = nd;
         end
         cm = bnd && (m_flag || data_valid);
         if (data_valid) for (int i = 0; i < ND; i++) m_pend[i] = digit_data[4*i +: 4];
         if (cm) begin
            for (int i = 0; i < ND; i++) m_shad[i] = m_pend[i];
            m_flag = 1'b0;
         end else if (data_valid) m_flag = 1'b1;
         m_commit = cm;
         m_bm = blink_mask;
      end
   end

   function automatic logic [6:0] exp_trans();
      logic [6:0] t;
      t = 7'h7F;
      if (m_pos >= BC) t[m_dig] = 1'b0;
      return t;
   endfunction

   function automatic logic [6:0] exp_led();
      if (m_pos < BC) return 7'h7F;
      if (BLINK_ON && ((m_n / BD) % 2 == 1) && m_bm[m_dig]) return 7'h7F;
      return glyph(m_shad[m_dig]);
   endfunction

   always @(negedge clk) begin
      if (m_live) begin
         chk("model_trans", trans, exp_trans());
         chk("model_led7seg", led7seg, exp_led());
         chk("model_commit", commit, m_commit);
         chk("model_cur_digit", cur_digit, m_dig[2:0]);
      end
   end

   task automatic cyc_to(input int k);
      int guard;
      guard = 0;
      while (m_n < k && guard < 5000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 5000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL cycle_wait: got cycle %0d, expected %0d", m_n, k);
      end
   endtask

   task automatic look(input int k);
      cyc_to(k);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drive_dv(input logic [4*ND-1:0] d);
      data_valid = 1'b1;
      digit_data = d;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, full scan, first commit at the 6->0 wrap
      digit_en = 7'h7F;
      do_reset();
      look(0);
      chk("rst_trans", trans, 7'h7F);
      chk("rst_led7seg", led7seg, 7'h7F);
      chk("rst_commit", commit, 1'b0);
      chk("rst_cur_digit", cur_digit, 3'd0);
      drive_dv(28'h6543210);
      look(35);
      chk("t1_trans_d3", trans, 7'h77);
      chk("t1_old_blank", led7seg, 7'h7F);
      chk("t1_cur3", cur_digit, 3'd3);
      look(70);
      chk("t1_commit", commit, 1'b1);
      chk("t1_wrap_cur", cur_digit, 3'd0);
      look(105);
      chk("t1_glyph3", led7seg, 7'h30);
      chk("t1_trans3b", trans, 7'h77);

      // Sparse enable 0,2,5 plus buffered and bypass commits
      digit_en = 7'h25;
      do_reset();
      drive_dv(28'h6543210);
      look(15);
      chk("t2_cur2", cur_digit, 3'd2);
      chk("t2_trans2", trans, 7'h7B);
      look(25);
      chk("t2_cur5", cur_digit, 3'd5);
      chk("t2_trans5", trans, 7'h5F);
      look(30);
      chk("t2_wrap0", cur_digit, 3'd0);
      chk("t2_commit", commit, 1'b1);
      cyc_to(42);
      drive_dv(28'h8888888);
      look(45);
      chk("t3_old_glyph", led7seg, 7'h24);
      look(60);
      chk("t3_commit", commit, 1'b1);
      look(61);
      chk("t3_commit_once", commit, 1'b0);
      look(62);
      chk("t3_glyph8", led7seg, 7'h00);
      chk("t3_trans0", trans, 7'h7E);
      cyc_to(89);
      drive_dv(28'h1111111);
      look(90);
      chk("t4_bypass_commit", commit, 1'b1);
      look(92);
      chk("t4_bypass_glyph", led7seg, 7'h79);
      cyc_to(100);
      drive_dv(28'h2222222);
      cyc_to(119);
      drive_dv(28'h3333333);
      look(120);
      chk("t4_commit2", commit, 1'b1);
      look(122);
      chk("t4_bypass_new", led7seg, 7'h30);
      look(150);
      chk("t4_flag_clear", commit, 1'b0);

      // Blink on digit 0 only
      digit_en = 7'h03;
      blink_mask = 7'h01;
      do_reset();
      drive_dv(28'h0000010);
      look(25);
      chk("t5_d0_phase0", led7seg, 7'h40);
      look(45);
      chk("t5_d0_phase1", led7seg, BLINK_ON ? 7'h7F : 7'h40);
      look(55);
      chk("t5_d1_unmasked", led7seg, 7'h79);
      look(65);
      chk("t5_d0_phase1b", led7seg, BLINK_ON ? 7'h7F : 7'h40);
      look(85);
      chk("t5_d0_phase0b", led7seg, 7'h40);

      // Abort, all-disabled idle, mid-drive reset
      blink_mask = '0;
      digit_en = 7'h7F;
      do_reset();
      drive_dv(28'h6543210);
      cyc_to(24);
      digit_en = 7'h7B;
      look(25);
      chk("t6_abort_trans", trans, 7'h7F);
      chk("t6_abort_next", cur_digit, 3'd3);
      look(27);
      chk("t6_d3_drive", trans, 7'h77);
      cyc_to(40);
      digit_en = '0;
      look(41);
      chk("t6_off_trans", trans, 7'h7F);
      chk("t6_off_led", led7seg, 7'h7F);
      chk("t6_off_commit", commit, 1'b1);
      cyc_to(50);
      drive_dv(28'h9999999);
      look(51);
      chk("t6_idle_commit", commit, 1'b1);
      look(90);
      chk("t6_idle_trans", trans, 7'h7F);
      chk("t6_idle_led", led7seg, 7'h7F);
      cyc_to(100);
      digit_en = 7'h7F;
      look(102);
      chk("t6_resume_trans", trans, 7'h6F);
      chk("t6_resume_led", led7seg, 7'h10);
      chk("t6_resume_cur", cur_digit, 3'd4);
      cyc_to(105);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_trans", trans, 7'h7F);
      chk("t6_rst_led", led7seg, 7'h7F);
      chk("t6_rst_cur", cur_digit, 3'd0);
      look(30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_scheduler.md
# seg7_scan_scheduler

Time-multiplexing scheduler for the shared 7-digit, 7-segment display bus (`TRANS` digit drivers plus common `LED7SEG` segment lines). It grants the segment bus round-robin to enabled digits only, inserts a blanking interval before every digit slot to suppress ghosting, and double-buffers display data so updates commit atomically at frame boundaries. It sits between `controller` (which produces per-digit values) and the top-level `TRANS`/`LED7SEG` registers.

## Interface
Parameters:
- `NUM_DIGITS`, 7: number of multiplexed digits.
- `SCAN_DIV`, 50000: clocks per digit slot, including blanking (1 kHz slot rate at 50 MHz).
- `BLANK_CYCLES`, 500: blanking clocks at the start of each slot; must satisfy 1 ≤ BLANK_CYCLES < SCAN_DIV.
- `BLINK_DIV`, 12500000: clocks per blink half-period (4 Hz toggle at 50 MHz).

Ports:
- `clk`, in, 1: system clock. One clock domain; reset is synchronous and active-high.
- `rst`, in, 1: synchronous, active-high reset.
- `digit_data`, in, 4*NUM_DIGITS: nibble i (bits 4i+3:4i) holds the code for digit i.
- `data_valid`, in, 1: single-cycle strobe that captures `digit_data` into the pending buffer.
- `digit_en`, in, NUM_DIGITS: live mask; 1 = digit takes part in the scan.
- `blink_mask`, in, NUM_DIGITS: 1 = digit blinks.
- `trans`, out, NUM_DIGITS: digit drivers, active-low, one-hot-low or all-high.
- `led7seg`, out, 7: segments {g,f,e,d,c,b,a}, active-low.
- `commit`, out, 1: one-cycle pulse when pending data is copied to the shadow (display) buffer.
- `cur_digit`, out, clog2(NUM_DIGITS): index of the current slot.

## Operation
- Reset values: `trans`=all 1, `led7seg`=7'h7F, `commit`=0, `cur_digit`=0, state BLANK, slot counter 0, pending and shadow buffers all 4'hF, blink phase 0, pending-flag 0.
- Decode: 0–9 map to standard glyphs, 4'hA maps to '-' (g only), 4'hB–4'hF map to blank.
- There are two states:
  - BLANK: `trans` all 1 and `led7seg`=7'h7F for BLANK_CYCLES clocks, then go to DRIVE.
  - DRIVE: `trans[cur_digit]`=0 and `led7seg`=decode(shadow[cur_digit]) for SCAN_DIV−BLANK_CYCLES clocks, then go to BLANK of the next slot.
- Next slot: the lowest enabled index strictly above `cur_digit`. If none exists, wrap to the lowest enabled index; that wrap is a frame boundary.
- With exactly one digit enabled, every slot is a frame boundary.
- If `digit_en` is all zero, stay in BLANK with outputs off and the counter held at 0. Each cycle in this condition counts as a frame boundary.
- If `digit_en[cur_digit]` deasserts during DRIVE, abort the slot: the next edge enters BLANK of the next slot.
- Data buffering:
  - `data_valid` writes `digit_data` to the pending buffer and sets the pending-flag.
  - At a frame boundary with the flag set, pending is copied to shadow, the flag clears, and `commit` pulses.
  - If `data_valid` coincides with a commit edge, the incoming word bypasses straight to shadow.
- Blink: a free-running counter toggles the blink phase every BLINK_DIV clocks. While the phase is 1, digits set in `blink_mask` drive `led7seg`=7'h7F during DRIVE. `trans` still sequences normally.

## Timing
- All outputs are registered. `trans` and `led7seg` change on the edge that changes state.
- Slot period is exactly SCAN_DIV clocks. The dark time between two digits is exactly BLANK_CYCLES clocks.
- `commit` is asserted during the first BLANK cycle of the committed frame. New data is visible from that frame's first DRIVE.
- `data_valid` to visible latency is at most one frame plus BLANK_CYCLES.
- `rst` mid-slot takes effect on the next edge: outputs go off and state returns to the reset values above.
- Counter widths: clog2(SCAN_DIV) and clog2(BLINK_DIV). Counters wrap to 0 at terminal count−1.

## Configuration
- `SEG7_BLINK_EN` defined: blink counter and masking logic are built as described under Operation.
- `SEG7_BLINK_EN` undefined: no blink counter is built and `blink_mask` is ignored. Digits are never masked.

## Structure
- Shared package `seg7_pkg`:
  - constants `SEG_OFF`=7'h7F and `CODE_BLANK`=4'hF,
  - glyph constants for 0–9 and '-',
  - scan state enum {BLANK, DRIVE}.
- Sub-module `seg7_decoder`: combinational 4-bit to active-low 7-bit decoder, instanced once on the shadow nibble selected by `cur_digit`.

## Test plan
Bench parameters: SCAN_DIV=10, BLANK_CYCLES=2, BLINK_DIV=40, SEG7_BLINK_EN defined.
1. Reset, all digits enabled, data 0..6 loaded.
   - Cycles 0–1 of each slot: trans=7'h7F.
   - Cycles 2–9: trans has bit i low.
   - Digit 3 shows led7seg=7'h30.
   - Order is 0..6, then wraps.
2. digit_en=7'b0100101: slots visit 0, 2, 5, 0, each exactly 10 clocks. The frame boundary comes at the wrap 5→0.
3. data_valid mid-frame with 4'h8 on all digits:
   - the old glyphs continue until the wrap;
   - `commit` pulses once;
   - the next DRIVE shows 7'h00.
4. data_valid on the same cycle as a commit edge: the new data appears in that same frame. The pending-flag stays 0.
5. blink_mask=7'b0000001: digit 0 shows its glyph for 40 clocks, then 7'h7F for 40 clocks. Digit 1 is never masked.
6. Edge cases:
   - digit_en→0 during DRIVE of digit 2: next edge gives trans=7'h7F.
   - digit_en all 0: outputs stay off indefinitely.
   - rst pulse mid-DRIVE: outputs are off next cycle and cur_digit=0.
